// File: rtl/gnrl_dconv_acq_ctrl_pkg.sv
// Shared definitions for the downconverter acquisition sequencer: FSM state
// encodings, parameter defaults and the post-delay routing helper.
package gnrl_dconv_acq_ctrl_pkg;

  localparam int ADC_PHYS_WIDTH_DEF = 14;
  localparam int DLY_WIDTH_DEF      = 16;
  localparam int CNT_WIDTH_DEF      = 24;
  localparam int CAL_LOG2_DEF       = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_CAL   = 3'd2,
    ST_ACQ   = 3'd3,
    ST_DONE  = 3'd4
  } acq_state_e;

  // State that follows the programmed delay: calibration if present, else
  // acquisition, else straight to DONE when no samples were requested.
  function automatic acq_state_e post_delay_state(input logic cal_present,
                                                  input logic zero_samples);
    if (cal_present) begin
      return ST_CAL;
    end else if (zero_samples) begin
      return ST_DONE;
    end else begin
      return ST_ACQ;
    end
  endfunction

endpackage

// File: rtl/gnrl_dconv_dc_est.sv
// ADC DC-level estimator: sums 2**CAL_LOG2 consecutive samples and presents the
// truncated mean (including the current sample) on the last accumulate cycle.
module gnrl_dconv_dc_est
  import gnrl_dconv_acq_ctrl_pkg::*;
#(
  parameter int ADC_PHYS_WIDTH = ADC_PHYS_WIDTH_DEF,
  parameter int CAL_LOG2       = CAL_LOG2_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      acc_en_i,
  input  logic [ADC_PHYS_WIDTH-1:0] sample_i,
  output logic                      last_o,
  output logic [ADC_PHYS_WIDTH-1:0] mean_o
);

  localparam int ACC_W = ADC_PHYS_WIDTH + CAL_LOG2;

  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [CAL_LOG2-1:0] cnt_q, cnt_d;

  assign acc_sum = acc_q + ACC_W'(sample_i);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The window's final sample is folded in combinationally so the mean is ready on exit.
  assign last_o = acc_en_i & ~clear_i & (&cnt_q);
  assign mean_o = acc_sum[ACC_W-1:CAL_LOG2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gnrl_dconv_acq_ctrl.sv
// Acquisition sequencer for the no-filter I/Q downconverter: start -> delay ->
// optional DC calibration (GNRL_DCONV_DCCAL_EN) -> N conv_en cycles -> done pulse.
module gnrl_dconv_acq_ctrl
  import gnrl_dconv_acq_ctrl_pkg::*;
#(
  parameter int ADC_PHYS_WIDTH = ADC_PHYS_WIDTH_DEF,
  parameter int DLY_WIDTH      = DLY_WIDTH_DEF,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int CAL_LOG2       = CAL_LOG2_DEF
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             start,
  input  logic                             abort,
  input  logic [DLY_WIDTH-1:0]             cfg_delay,
  input  logic [CNT_WIDTH-1:0]             cfg_nsamples,
  input  logic signed [ADC_PHYS_WIDTH:0]   dcval_static,
  input  logic [ADC_PHYS_WIDTH-1:0]        adc_data_in,
  output logic                             conv_en,
  output logic signed [ADC_PHYS_WIDTH:0]   adc_dcval_subtractor,
  output logic                             busy,
  output logic                             done,
  output logic [CNT_WIDTH-1:0]             sample_cnt
);

  acq_state_e                    state_q, state_d;
  logic [DLY_WIDTH-1:0]          dly_q, dly_d;
  logic [CNT_WIDTH-1:0]          nsamp_q, nsamp_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic signed [ADC_PHYS_WIDTH:0] sub_q, sub_d;
  logic                          conv_en_q, busy_q, done_q;
  logic                          cal_last;
  logic [ADC_PHYS_WIDTH-1:0]     cal_mean;

`ifdef GNRL_DCONV_DCCAL_EN
  localparam logic CAL_PRESENT = 1'b1;

  gnrl_dconv_dc_est #(
    .ADC_PHYS_WIDTH (ADC_PHYS_WIDTH),
    .CAL_LOG2       (CAL_LOG2)
  ) u_dc_est (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .clear_i  (state_q != ST_CAL),
    .acc_en_i (state_q == ST_CAL),
    .sample_i (adc_data_in),
    .last_o   (cal_last),
    .mean_o   (cal_mean)
  );
`else
  localparam logic CAL_PRESENT = 1'b0;
  logic adc_unused;

  assign cal_last   = 1'b1;
  assign cal_mean   = '0;
  assign adc_unused = ^adc_data_in;
`endif

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    nsamp_d = nsamp_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dly_d   = cfg_delay;
            nsamp_d = cfg_nsamples;
            cnt_d   = '0;
            if (!CAL_PRESENT) begin
              sub_d = dcval_static;
            end
            state_d = (cfg_delay == '0) ?
                      post_delay_state(CAL_PRESENT, cfg_nsamples == '0) : ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (dly_q <= DLY_WIDTH'(1)) begin
            state_d = post_delay_state(CAL_PRESENT, nsamp_q == '0);
          end else begin
            dly_d = dly_q - 1'b1;
          end
        end
        ST_CAL: begin
          if (cal_last) begin
            sub_d   = {1'b0, cal_mean};
            state_d = (nsamp_q == '0) ? ST_DONE : ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (cnt_q == nsamp_q) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      // sample_cnt already counts the conv_en cycle being issued.
      if (state_d == ST_ACQ && cnt_d != nsamp_d) begin
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      dly_q     <= '0;
      nsamp_q   <= '0;
      cnt_q     <= '0;
      sub_q     <= '0;
      conv_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      nsamp_q   <= nsamp_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      conv_en_q <= (state_d == ST_ACQ);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign conv_en              = conv_en_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign sample_cnt           = cnt_q;
  assign adc_dcval_subtractor = sub_q;

endmodule

// File: tb/tb_gnrl_dconv_acq_ctrl.sv
// Self-checking bench for gnrl_dconv_acq_ctrl; expectations come from a cycle-index
// model of each run (delay, calibration window, N samples, abort point).
module tb_gnrl_dconv_acq_ctrl;

  localparam int ADC_W = 14;
  localparam int DLY_W = 16;
  localparam int CNT_W = 24;
  localparam int CAL_L = 4;
`ifdef GNRL_DCONV_DCCAL_EN
  localparam int CAL_C = 1 << CAL_L;
`else
  localparam int CAL_C = 0;
`endif

  logic                    CLK = 1'b0;
  logic                    RESET = 1'b1;
  logic                    start = 1'b0;
  logic                    abort = 1'b0;
  logic [DLY_W-1:0]        cfg_delay = '0;
  logic [CNT_W-1:0]        cfg_nsamples = '0;
  logic signed [ADC_W:0]   dcval_static = '0;
  logic [ADC_W-1:0]        adc_data_in = '0;
  logic                    conv_en;
  logic signed [ADC_W:0]   adc_dcval_subtractor;
  logic                    busy;
  logic                    done;
  logic [CNT_W-1:0]        sample_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int run_id   = 0;
  int sub_model = 0;
  int cnt_model = 0;

  gnrl_dconv_acq_ctrl #(
    .ADC_PHYS_WIDTH (ADC_W),
    .DLY_WIDTH      (DLY_W),
    .CNT_WIDTH      (CNT_W),
    .CAL_LOG2       (CAL_L)
  ) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .start                (start),
    .abort                (abort),
    .cfg_delay            (cfg_delay),
    .cfg_nsamples         (cfg_nsamples),
    .dcval_static         (dcval_static),
    .adc_data_in          (adc_data_in),
    .conv_en              (conv_en),
    .adc_dcval_subtractor (adc_dcval_subtractor),
    .busy                 (busy),
    .done                 (done),
    .sample_cnt           (sample_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int adc_sample(input int mode, input int k);
    if (mode == 1) return 1024;
    if (mode == 2) return (k % 2 == 1) ? 1003 : 1000;
    return int'($urandom_range(0, 16383));
  endfunction

  // One start-to-idle run; abort_at=0 means no abort, otherwise the cycle index
  // (start cycle = 0) during which abort is held high.
  task automatic run(input int d, input int n, input int dcs, input int mode,
                     input int abort_at);
    int a, dn, sum, busy_start_at, exp_conv, exp_busy, exp_done, exp_cnt;
    bit aborted;
    a   = 1 + d + CAL_C;
    dn  = a + n;
    sum = 0;
    aborted = 1'b0;
    busy_start_at = int'($urandom_range(1, dn));
    if (abort_at > 0 && busy_start_at > abort_at) busy_start_at = abort_at;
    run_id++;

    @(posedge CLK); #1;
    cfg_delay    = DLY_W'(d);
    cfg_nsamples = CNT_W'(n);
    dcval_static = (ADC_W+1)'(dcs);
    adc_data_in  = ADC_W'(adc_sample(mode, 0));
    abort = 1'b0;
    start = 1'b1;
    @(posedge CLK); #1;
    cnt_model = 0;
    if (CAL_C == 0) sub_model = dcs;

    for (int k = 1; k <= dn + 3; k++) begin
      cfg_delay    = DLY_W'($urandom_range(0, 9));
      cfg_nsamples = CNT_W'($urandom_range(0, 40));
      dcval_static = (ADC_W+1)'($urandom);
      adc_data_in  = ADC_W'(adc_sample(mode, k));
      if (k >= 1 + d && k < a) sum += int'(adc_data_in);
      start = (k == busy_start_at);
      abort = (k == abort_at);
      @(negedge CLK);
      if (aborted) begin
        exp_conv = 0; exp_busy = 0; exp_done = 0;
      end else begin
        if (CAL_C != 0 && k == a) sub_model = sum / CAL_C;
        exp_conv  = (k >= a && k < a + n) ? 1 : 0;
        exp_busy  = (k <= dn) ? 1 : 0;
        exp_done  = (k == dn) ? 1 : 0;
        cnt_model = (k < a) ? 0 : ((k - a + 1 < n) ? k - a + 1 : n);
      end
      chk($sformatf("conv_en run%0d k%0d", run_id, k), int'(conv_en), exp_conv);
      chk($sformatf("busy run%0d k%0d", run_id, k), int'(busy), exp_busy);
      chk($sformatf("done run%0d k%0d", run_id, k), int'(done), exp_done);
      chk($sformatf("sample_cnt run%0d k%0d", run_id, k), int'(sample_cnt), cnt_model);
      if (CAL_C == 0 || k >= a || aborted)
        chk($sformatf("subtractor run%0d k%0d", run_id, k),
            int'(adc_dcval_subtractor), sub_model);
      if (k == abort_at) aborted = 1'b1;
      @(posedge CLK); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    $display("run %0d: delay=%0d nsamples=%0d mode=%0d abort_at=%0d start_while_busy=%0d sub=%0d cnt=%0d",
             run_id, d, n, mode, abort_at, busy_start_at, sub_model, cnt_model);
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset conv_en", int'(conv_en), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset sample_cnt", int'(sample_cnt), 0);
    chk("reset subtractor", int'(adc_dcval_subtractor), 0);
    @(posedge CLK); #1 RESET = 1'b0;

    run(4, 10, 9400, 0, 0);          // nominal sequence
    run(0, 8, 5000, 1, 0);           // zero delay, constant ADC level
    run(3, 6, -200, 2, 0);           // alternating 1000/1003 -> truncated mean
    run(2, 0, 77, 0, 0);             // no samples: done without conv_en
    run(1, 8, 1234, 0, 1 + 1 + CAL_C + 2);  // abort on 3rd ACQ cycle
    run(5, 4, 321, 0, 3);            // abort during delay

    // abort and start together while idle: run must not start
    @(posedge CLK); #1;
    cfg_delay = 1; cfg_nsamples = 5; start = 1'b1; abort = 1'b1;
    @(posedge CLK); #1 start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("abort+start busy k%0d", k), int'(busy), 0);
      chk($sformatf("abort+start conv_en k%0d", k), int'(conv_en), 0);
    end
    $display("abort+start in idle: busy=%0d", busy);

    // asynchronous reset in the middle of acquisition
    @(posedge CLK); #1;
    cfg_delay = 2; cfg_nsamples = 20; dcval_static = 15'sd555; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (CAL_C + 5) @(posedge CLK);
    #1 chk("pre-reset conv_en", int'(conv_en), 1);
    #1 RESET = 1'b1;
    #1;
    chk("async reset conv_en", int'(conv_en), 0);
    chk("async reset busy", int'(busy), 0);
    chk("async reset done", int'(done), 0);
    chk("async reset sample_cnt", int'(sample_cnt), 0);
    chk("async reset subtractor", int'(adc_dcval_subtractor), 0);
    $display("async reset mid-ACQ: conv_en=%0d sample_cnt=%0d", conv_en, sample_cnt);
    sub_model = 0;
    @(posedge CLK); #1 RESET = 1'b0;
    run(2, 7, 9400, 1, 0);           // full run after reset release

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      int d, n, ab, dn;
      d  = int'($urandom_range(0, 6));
      n  = int'($urandom_range(0, 12));
      dn = 1 + d + CAL_C + n;
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, dn)) : 0;
      run(d, n, int'($urandom_range(0, 16383)), 0, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
